// File: rtl/locked_core_sched_if.sv
// Signal bundle between locked_core_sched, its two requesters, the key source
// and the external key-locked c1355 core.
interface locked_core_sched_if #(
    parameter int IN_W  = 41,
    parameter int OUT_W = 32,
    parameter int KEY_W = 8
);
    logic             key_wr;
    logic [KEY_W-1:0] key_data;
    logic             key_clr;
    logic             key_ok;
    logic [1:0]       req;
    logic [IN_W-1:0]  req_vec0;
    logic [IN_W-1:0]  req_vec1;
    logic [1:0]       ack;
    logic [IN_W-1:0]  core_in;
    logic [KEY_W-1:0] core_key;
    logic [OUT_W-1:0] core_out;
    logic             resp_valid;
    logic [OUT_W-1:0] resp_data;
    logic             resp_id;
    logic             busy;

    modport slave (
        input  key_wr, key_data, key_clr, req, req_vec0, req_vec1, core_out,
        output key_ok, ack, core_in, core_key, resp_valid, resp_data, resp_id, busy
    );

    modport master (
        output key_wr, key_data, key_clr, req, req_vec0, req_vec1, core_out,
        input  key_ok, ack, core_in, core_key, resp_valid, resp_data, resp_id, busy
    );
endinterface

// File: rtl/locked_core_sched.sv
// Sequencer for the key-locked c1355 core: holds the key, round-robin arbitrates
// two requesters, holds the core inputs for SETTLE_CYC cycles and returns the result.
module locked_core_sched #(
    parameter int IN_W       = 41,
    parameter int OUT_W      = 32,
    parameter int KEY_W      = 8,
    parameter int SETTLE_CYC = 2    // legal range 1..15, fits the 4-bit counter
) (
    input logic                clk,
    input logic                rst,
    locked_core_sched_if.slave bus
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE
    } state_e;

    state_e           state_q;
    logic [KEY_W-1:0] key_q;
    logic             key_ok_q;
    logic [KEY_W-1:0] core_key_q;
    logic [IN_W-1:0]  core_in_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       ack_q;
    logic             id_q;
    logic             rr_ptr_q;
    logic             busy_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [OUT_W-1:0] resp_data_q;

    logic             grant_d;
    logic             grant_id_d;
    logic [KEY_W-1:0] key_d;

    always_comb begin
        grant_d    = (state_q == S_IDLE) && key_ok_q && (bus.req != 2'b00) && !bus.key_clr;
        grant_id_d = (bus.req == 2'b11) ? rr_ptr_q : bus.req[1];
        // A key written in the same IDLE cycle as a grant is the one the core sees.
        key_d      = ((state_q == S_IDLE) && bus.key_wr) ? bus.key_data : key_q;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            key_ok_q     <= 1'b0;
            core_key_q   <= '0;
            core_in_q    <= '0;
            cnt_q        <= '0;
            ack_q        <= '0;
            id_q         <= 1'b0;
            rr_ptr_q     <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            // NOTE: pulse outputs default low here, so each branch only raises them.
            ack_q        <= '0;
            resp_valid_q <= 1'b0;
            if (bus.key_clr) begin
                key_q      <= '0;
                key_ok_q   <= 1'b0;
                core_key_q <= '0;
                core_in_q  <= '0;
                busy_q     <= 1'b0;
                state_q    <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.key_wr) begin
                            key_q    <= bus.key_data;
                            key_ok_q <= 1'b1;
                        end
                        if (grant_d) begin
                            ack_q      <= grant_id_d ? 2'b10 : 2'b01;
                            core_in_q  <= grant_id_d ? bus.req_vec1 : bus.req_vec0;
                            core_key_q <= key_d;
                            id_q       <= grant_id_d;
                            cnt_q      <= CNT_W'(SETTLE_CYC - 1);
                            busy_q     <= 1'b1;
                            state_q    <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == '0) state_q <= S_CAPTURE;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                    S_CAPTURE: begin
                        resp_data_q  <= bus.core_out;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        rr_ptr_q     <= ~id_q;
                        core_in_q    <= '0;
                        core_key_q   <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.key_ok     = key_ok_q;
    assign bus.ack        = ack_q;
    assign bus.core_in    = core_in_q;
    assign bus.core_key   = core_key_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.busy       = busy_q;
endmodule
